// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcode constants, alu_op codes and the ALU-B / PC-source select encodings.
// Ports: none (package).
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JR    = 6'b000110;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  // States that wait on the unified memory and therefore count stalls.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // True for every opcode that has its own execution sequence.
  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control FSM for the MIPS datapath (R-type, lw, sw, beq, addi,
// slti, j, jr, jal). Outputs are decoded from the state; only FETCH, MEM_RD
// and MEM_WR look at mem_ready. A stall counter aborts a hung memory access
// and raises a sticky mem_err.
// Ports:
//   clk, rst (async, active-low)
//   opcode, zero, mem_ready                    : inputs
//   pc_write, pc_write_cond, i_or_d, mem_read,
//   mem_write, ir_write, mem_to_reg, reg_dst,
//   sel_reg, sel_wd, reg_write, alu_src_a,
//   alu_src_b, alu_op, pc_source               : datapath controls
//   instr_done                                 : final-state pulse
//   mem_err                                    : sticky stall timeout
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       sel_reg,
  output logic       sel_wd,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       mem_err
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              timeout_s;
  logic              stall_s;

  // The branch decision is taken outside (pc_write_cond & zero), so zero is
  // only carried through here.
  logic              zero_unused_s;
  assign zero_unused_s = zero;

  // Stall bookkeeping for the memory-facing states.
  always_comb begin
    timeout_s = is_mem_state(state_q) && (wait_cnt_q >= MAX_WAIT_C);
    stall_s   = is_mem_state(state_q) && !mem_ready;
  end

  // Next-state, latched opcode, stall counter and sticky error.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    mem_err_d  = mem_err_q;
    wait_cnt_d = '0;
    if (timeout_s) begin
      // Abandon the access; the instruction is dropped without instr_done.
      state_d   = S_FETCH;
      mem_err_d = 1'b1;
    end else begin
      if (stall_s) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end else begin
        wait_cnt_d = '0;
      end
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_d = S_DECODE;
          else           state_d = S_FETCH;
        end
        S_DECODE: begin
          opcode_d = opcode;
          case (opcode)
            OP_RTYPE:       state_d = S_R_EXEC;
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ:         state_d = S_BEQ;
            OP_ADDI,
            OP_SLTI:        state_d = S_I_EXEC;
            OP_J:           state_d = S_JUMP;
            OP_JR:          state_d = S_JR;
            OP_JAL:         state_d = S_JAL;
            default:        state_d = S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode_q == OP_SW) state_d = S_MEM_WR;
          else                   state_d = S_MEM_RD;
        end
        S_MEM_RD: begin
          if (mem_ready) state_d = S_LW_WB;
          else           state_d = S_MEM_RD;
        end
        S_MEM_WR: begin
          if (mem_ready) state_d = S_FETCH;
          else           state_d = S_MEM_WR;
        end
        S_R_EXEC: state_d = S_R_WB;
        S_I_EXEC: state_d = S_I_WB;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Moore output decode; everything is held low in reset and in the abort cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    sel_reg       = 1'b0;
    sel_wd        = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    pc_source     = PC_SRC_ALU;
    instr_done    = 1'b0;
    if (!rst || timeout_s) begin
      instr_done = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRC_B_IMM_SH;
          instr_done = !is_known_op(opcode);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_LW_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNC;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_op    = (opcode_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_source  = PC_SRC_REG;
          instr_done = 1'b1;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          sel_reg    = 1'b1;
          sel_wd     = 1'b1;
          pc_write   = 1'b1;
          pc_source  = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
        default: begin
          instr_done = 1'b0;
        end
      endcase
    end
  end

  assign mem_err = rst & mem_err_q;

  // State register, latched opcode, stall counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      opcode_q   <= 6'b000000;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control FSM for the MIPS datapath. It decodes the same instruction subset as the single-cycle controller: R-type, lw, sw, beq, addi, j, jr, slti and jal. Each instruction is sequenced over 3-5 states that share one ALU and one unified memory. A mem_ready handshake stalls memory states, and a bounded wait counter flags a hung memory.

Parameters:
MAX_WAIT, 15, maximum consecutive stall cycles in a memory state before mem_err is raised (range 1..255).
WAIT_W, 8, width of the stall counter; must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-low reset.
opcode  input  6  IR[31:26], sampled only in DECODE.
zero  input  1  ALU zero flag.
mem_ready  input  1  memory access complete this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond  output  1  PC load when zero=1.
i_or_d  output  1  memory address source: 0=PC, 1=ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  instruction register load.
mem_to_reg  output  1  write data source: 1=MDR, 0=ALUOut.
reg_dst  output  1  write register: 1=rd, 0=rt.
sel_reg  output  1  forces write register to R31 (jal).
sel_wd  output  1  write data = PC (jal); overrides mem_to_reg.
reg_write  output  1  register file write enable.
alu_src_a  output  1  0=PC, 1=A.
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
alu_op  output  2  00=add, 01=sub, 10=funct, 11=slt; decoded by the existing ALU control block.
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],imm26,00}, 11=A (jr).
instr_done  output  1  one-cycle pulse in the final state of each instruction.
mem_err  output  1  sticky; set on stall timeout, cleared only by reset.

Behaviour:
- The state register is 4-bit. Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BEQ=8, I_EXEC=9, I_WB=10, JUMP=11, JR=12, JAL=13.
- Reset (rst=0, async): state goes to FETCH, wait_cnt=0, mem_err=0. All outputs are forced to 0 while rst=0.
- Outputs are Moore (decoded from the state). The only exception is gating by mem_ready in FETCH, MEM_RD and MEM_WR. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00.
  - pc_write=1 and ir_write=1 only when mem_ready=1; then go to DECODE. Otherwise hold.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BEQ
  - 001001 / 001010 -> I_EXEC
  - 000010 -> JUMP
  - 000110 -> JR
  - 000011 -> JAL
  - any other opcode -> FETCH, with an instr_done pulse (treated as NOP).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD for lw, MEM_WR for sw. The opcode is held in an internal register latched in DECODE.
- MEM_RD: mem_read=1, i_or_d=1. Go to LW_WB when mem_ready=1.
- LW_WB: reg_write=1, mem_to_reg=1, reg_dst=0. instr_done=1. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. When mem_ready=1: instr_done=1, go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1. instr_done=1. Go to FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. instr_done=1. Go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 11 for slti. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. instr_done=1. Go to FETCH.
- JR: pc_write=1, pc_source=11. instr_done=1. Go to FETCH.
- JAL: reg_write=1, sel_reg=1, sel_wd=1 (PC already holds PC+4), pc_write=1, pc_source=10. instr_done=1. Go to FETCH.
- Latency: FETCH+DECODE plus:
  - 1 cycle: j, jr, jal, beq
  - 2 cycles: R-type, addi, slti, sw
  - 3 cycles: lw
  - plus any stall cycles.
- Stall counter:
  - wait_cnt increments each cycle a memory state waits with mem_ready=0.
  - It resets to 0 on state change.
  - When wait_cnt reaches MAX_WAIT: mem_err is set, wait_cnt clears, and the FSM goes to FETCH with no strobes issued that cycle. The aborted instruction gives no instr_done.
- mem_ready=1 outside memory states is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial strobes are issued after rst falls.

Decomposition:
- Shared package contains:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JR, OP_SLTI, OP_JAL)
  - alu_op codes (ALU_ADD, ALU_SUB, ALU_FUNC, ALU_SLT)
  - alu_src_b and pc_source encodings
- No sub-module. The next-state logic, output decode and stall counter live in one module. The existing ALU control block stays outside and is fed by alu_op.

Test Plan:
- Reset then add (opcode 000000), mem_ready=1 -> states 0,1,6,7. In R_WB: reg_write=1, reg_dst=1, instr_done=1. Back to FETCH in cycle 5.
- lw with mem_ready low 3 cycles in MEM_RD -> FSM holds MEM_RD for 3 cycles, no ir_write/reg_write. LW_WB asserts mem_to_reg=1, reg_write=1. Total 8 cycles.
- beq with zero=1, then zero=0 -> pc_write_cond=1, pc_source=01 in BEQ both times. 3 cycles each, instr_done pulses.
- jal -> JAL state asserts reg_write=1, sel_reg=1, sel_wd=1, pc_write=1, pc_source=10. jr asserts pc_source=11.
- MAX_WAIT=4, sw with mem_ready stuck at 0 -> mem_err rises after 4 stall cycles. FSM returns to FETCH, mem_write never coincides with mem_ready, no instr_done.
- Unknown opcode 111111 -> FETCH after DECODE with instr_done=1. Async rst=0 mid-R_EXEC -> all outputs 0 immediately, state=FETCH after release.
